// File: rtl/shift_unit_arbiter_if.sv
// -----------------------------------------------------------------------------
// shift_unit_arbiter_if
// Purpose : bundles the two requester lanes, the shared shifter drive/return,
//           the result handshake and the pipeline flush of shift_unit_arbiter.
// Signals : i_flush                          pipeline flush
//           i_reqN_valid/data/amt/mode/tag   lane N request (N = 0 older slot)
//           o_reqN_ready                     lane N grant
//           o_sh_data/amt/mode, i_sh_result  shared combinational shifter
//           o_res_valid/data/tag/lane        registered result
//           i_res_ready                      result consumer ready
// Modports: slave  - the arbiter side
//           master - the environment (requesters, shifter, consumer)
// -----------------------------------------------------------------------------
interface shift_unit_arbiter_if #(
  parameter int unsigned TAG_W = 6
);
  logic             i_flush;

  logic             i_req0_valid;
  logic [31:0]      i_req0_data;
  logic [4:0]       i_req0_amt;
  logic [1:0]       i_req0_mode;
  logic [TAG_W-1:0] i_req0_tag;
  logic             o_req0_ready;

  logic             i_req1_valid;
  logic [31:0]      i_req1_data;
  logic [4:0]       i_req1_amt;
  logic [1:0]       i_req1_mode;
  logic [TAG_W-1:0] i_req1_tag;
  logic             o_req1_ready;

  logic [31:0]      o_sh_data;
  logic [4:0]       o_sh_amt;
  logic [1:0]       o_sh_mode;
  logic [31:0]      i_sh_result;

  logic             o_res_valid;
  logic [31:0]      o_res_data;
  logic [TAG_W-1:0] o_res_tag;
  logic             o_res_lane;
  logic             i_res_ready;

  modport slave (
    input  i_flush,
    input  i_req0_valid, i_req0_data, i_req0_amt, i_req0_mode, i_req0_tag,
    output o_req0_ready,
    input  i_req1_valid, i_req1_data, i_req1_amt, i_req1_mode, i_req1_tag,
    output o_req1_ready,
    output o_sh_data, o_sh_amt, o_sh_mode,
    input  i_sh_result,
    output o_res_valid, o_res_data, o_res_tag, o_res_lane,
    input  i_res_ready
  );

  modport master (
    output i_flush,
    output i_req0_valid, i_req0_data, i_req0_amt, i_req0_mode, i_req0_tag,
    input  o_req0_ready,
    output i_req1_valid, i_req1_data, i_req1_amt, i_req1_mode, i_req1_tag,
    input  o_req1_ready,
    input  o_sh_data, o_sh_amt, o_sh_mode,
    output i_sh_result,
    input  o_res_valid, o_res_data, o_res_tag, o_res_lane,
    output i_res_ready
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// -----------------------------------------------------------------------------
// shift_unit_arbiter
// Purpose : arbitrates two issue lanes onto one shared combinational 32-bit
//           shifter and registers the result with a valid/ready handshake.
//           Lane 0 (older slot) wins contention unless lane 1 has been denied
//           STARVE_LIMIT times in a row.
// Ports   : i_clk    rising-edge clock
//           i_reset  asynchronous active-high reset
//           bus      shift_unit_arbiter_if.slave (requests, shifter, result)
// -----------------------------------------------------------------------------
module shift_unit_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TAG_W        = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  shift_unit_arbiter_if.slave  bus
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0]       r_starve_cnt;
  logic             r_res_valid;
  logic [31:0]      r_res_data;
  logic [TAG_W-1:0] r_res_tag;
  logic             r_res_lane;

  logic             w_accept;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_xfer;
  logic [31:0]      w_sh_data;
  logic [4:0]       w_sh_amt;
  logic [1:0]       w_sh_mode;

  // Reset is folded into accept so readies and shifter drive are quiet while
  // reset is asserted, without waiting for a clock edge.
  assign w_accept = ~bus.i_flush & ~i_reset & (~r_res_valid | bus.i_res_ready);
  assign w_gnt1   = w_accept & bus.i_req1_valid &
                    (~bus.i_req0_valid | (r_starve_cnt == LIMIT));
  assign w_gnt0   = w_accept & bus.i_req0_valid & ~w_gnt1;
  assign w_xfer   = w_gnt0 | w_gnt1;

  assign bus.o_req0_ready = w_gnt0;
  assign bus.o_req1_ready = w_gnt1;

  // Steer the granted lane's operands onto the shared shifter.
  always_comb begin
    w_sh_data = 32'd0;
    w_sh_amt  = 5'd0;
    w_sh_mode = 2'd0;
    if (w_gnt1) begin
      w_sh_data = bus.i_req1_data;
      w_sh_amt  = bus.i_req1_amt;
      w_sh_mode = bus.i_req1_mode;
    end else if (w_gnt0) begin
      w_sh_data = bus.i_req0_data;
      w_sh_amt  = bus.i_req0_amt;
      w_sh_mode = bus.i_req0_mode;
    end else begin
      w_sh_data = 32'd0;
      w_sh_amt  = 5'd0;
      w_sh_mode = 2'd0;
    end
  end

  assign bus.o_sh_data = w_sh_data;
  assign bus.o_sh_amt  = w_sh_amt;
  assign bus.o_sh_mode = w_sh_mode;

  // Lane-1 starvation counter: counts consecutive contention losses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_starve_cnt <= 3'd0;
    end else if (bus.i_flush) begin
      r_starve_cnt <= 3'd0;
    end else if (w_accept) begin
      if (w_gnt1 || !bus.i_req1_valid) begin
        r_starve_cnt <= 3'd0;
      end else if (r_starve_cnt < LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 3'd1;
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  // Result valid: flush wins, then a new transfer, then consumption.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_res_valid <= 1'b0;
    end else if (bus.i_flush) begin
      r_res_valid <= 1'b0;
    end else if (w_xfer) begin
      r_res_valid <= 1'b1;
    end else if (bus.i_res_ready) begin
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= r_res_valid;
    end
  end

  // Result payload only loads on a transfer; it is left as-is when valid drops.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_res_data <= 32'd0;
      r_res_tag  <= '0;
      r_res_lane <= 1'b0;
    end else if (w_xfer) begin
      r_res_data <= bus.i_sh_result;
      r_res_tag  <= w_gnt1 ? bus.i_req1_tag : bus.i_req0_tag;
      r_res_lane <= w_gnt1;
    end else begin
      r_res_data <= r_res_data;
      r_res_tag  <= r_res_tag;
      r_res_lane <= r_res_lane;
    end
  end

  assign bus.o_res_valid = r_res_valid;
  assign bus.o_res_data  = r_res_data;
  assign bus.o_res_tag   = r_res_tag;
  assign bus.o_res_lane  = r_res_lane;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_arbiter
// Purpose : self-checking bench for shift_unit_arbiter. A behavioural model
//           tracks the result register and the run of lane-1 denials; a
//           behavioural shifter answers the DUT's shifter drive.
// -----------------------------------------------------------------------------
module tb_shift_unit_arbiter;
  localparam int TAG_W = 6;
  localparam int LIMIT = 3;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  // model state
  logic             m_valid;
  logic [31:0]      m_data;
  logic [TAG_W-1:0] m_tag;
  logic             m_lane;
  int               m_den;

  shift_unit_arbiter_if #(.TAG_W(TAG_W)) bus ();

  shift_unit_arbiter #(.STARVE_LIMIT(LIMIT), .TAG_W(TAG_W)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] shf(input logic [31:0] d, input logic [4:0] a,
                                      input logic [1:0] m);
    case (m)
      2'b00:   shf = d >> a;
      2'b01:   shf = d << a;
      2'b10:   shf = $unsigned($signed(d) >>> a);
      default: shf = d;
    endcase
  endfunction

  // behavioural shared shifter
  always_comb bus.i_sh_result = shf(bus.o_sh_data, bus.o_sh_amt, bus.o_sh_mode);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = 32'd0; m_tag = '0; m_lane = 1'b0; m_den = 0;
  endtask

  // One clock cycle with the currently driven inputs; called at posedge+1.
  task automatic cycle(output logic a_r0, output logic a_r1);
    int   win;
    logic acc;
    logic [31:0] ed; logic [4:0] ea; logic [1:0] em;
    #3;
    acc = !bus.i_flush && (!m_valid || bus.i_res_ready);
    win = -1;
    if (acc) begin
      if (bus.i_req0_valid && bus.i_req1_valid) win = (m_den >= LIMIT) ? 1 : 0;
      else if (bus.i_req0_valid) win = 0;
      else if (bus.i_req1_valid) win = 1;
    end
    ed = (win == 0) ? bus.i_req0_data : (win == 1) ? bus.i_req1_data : 32'd0;
    ea = (win == 0) ? bus.i_req0_amt  : (win == 1) ? bus.i_req1_amt  : 5'd0;
    em = (win == 0) ? bus.i_req0_mode : (win == 1) ? bus.i_req1_mode : 2'd0;
    a_r0 = bus.o_req0_ready;
    a_r1 = bus.o_req1_ready;
    chk("ready0", 32'(a_r0), 32'(win == 0));
    chk("ready1", 32'(a_r1), 32'(win == 1));
    chk("sh_data", bus.o_sh_data, ed);
    chk("sh_amt", 32'(bus.o_sh_amt), 32'(ea));
    chk("sh_mode", 32'(bus.o_sh_mode), 32'(em));
    @(posedge clk);
    if (bus.i_flush) begin
      m_valid = 1'b0;
      m_den   = 0;
    end else begin
      if (win >= 0) begin
        m_valid = 1'b1;
        m_data  = shf(ed, ea, em);
        m_tag   = (win == 1) ? bus.i_req1_tag : bus.i_req0_tag;
        m_lane  = (win == 1);
      end else if (m_valid && bus.i_res_ready) begin
        m_valid = 1'b0;
      end
      if (acc) m_den = (win == 0 && bus.i_req1_valid) ? ((m_den < LIMIT) ? m_den + 1 : m_den) : 0;
    end
    #1;
    chk("res_valid", 32'(bus.o_res_valid), 32'(m_valid));
    chk("res_data", bus.o_res_data, m_data);
    chk("res_tag", 32'(bus.o_res_tag), 32'(m_tag));
    chk("res_lane", 32'(bus.o_res_lane), 32'(m_lane));
  endtask

  task automatic set_req(input int lane, input logic v, input logic [31:0] d,
                         input logic [4:0] a, input logic [1:0] m, input logic [TAG_W-1:0] t);
    if (lane == 0) begin
      bus.i_req0_valid = v; bus.i_req0_data = d; bus.i_req0_amt = a;
      bus.i_req0_mode = m; bus.i_req0_tag = t;
    end else begin
      bus.i_req1_valid = v; bus.i_req1_data = d; bus.i_req1_amt = a;
      bus.i_req1_mode = m; bus.i_req1_tag = t;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic v0; logic v1; logic rr; logic e_r0; logic e_r1;
  } vec_t;

  initial begin
    vec_t        tbl [12];
    logic        r0, r1;
    logic [31:0] saved;
    n_pass = 0; n_total = 0;
    // contention run (grants 0,0,0,1 twice), single lanes, stall, idle
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    bus.i_flush = 1'b0; bus.i_res_ready = 1'b1;
    set_req(0, 1'b0, 32'd0, 5'd0, 2'd0, 6'd0);
    set_req(1, 1'b0, 32'd0, 5'd0, 2'd0, 6'd0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.o_res_valid), 32'd0);
    chk("rst_data", bus.o_res_data, 32'd0);
    chk("rst_tag", 32'(bus.o_res_tag), 32'd0);
    chk("rst_lane", 32'(bus.o_res_lane), 32'd0);
    rst = 1'b0;

    // single lane SRA
    set_req(0, 1'b1, 32'h8000_0001, 5'd4, 2'b10, 6'd5);
    cycle(r0, r1);
    chk("sra_ready0", 32'(r0), 32'd1);
    chk("sra_data", bus.o_res_data, 32'hF800_0000);
    chk("sra_tag", 32'(bus.o_res_tag), 32'd5);
    chk("sra_lane", 32'(bus.o_res_lane), 32'd0);

    // table vectors from a clean state
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.i_res_ready = tbl[i].rr;
      set_req(0, tbl[i].v0, 32'h1000_0000 * i + 32'd3, 5'(i), 2'(i), 6'(i));
      set_req(1, tbl[i].v1, 32'hA5A5_0000 + 32'(i), 5'(i + 1), 2'(i + 1), 6'(i + 32));
      cycle(r0, r1);
      chk($sformatf("tbl%0d_ready0", i), 32'(r0), 32'(tbl[i].e_r0));
      chk($sformatf("tbl%0d_ready1", i), 32'(r1), 32'(tbl[i].e_r1));
    end

    // backpressure: hold 4 cycles with lane 1 waiting
    bus.i_res_ready = 1'b1;
    set_req(0, 1'b1, 32'h0000_00F0, 5'd2, 2'b00, 6'd9);
    set_req(1, 1'b0, 32'd0, 5'd0, 2'd0, 6'd0);
    cycle(r0, r1);
    saved = bus.o_res_data;
    bus.i_res_ready = 1'b0;
    set_req(0, 1'b0, 32'd0, 5'd0, 2'd0, 6'd0);
    set_req(1, 1'b1, 32'h0000_0003, 5'd3, 2'b01, 6'd17);
    for (int i = 0; i < 4; i++) begin
      cycle(r0, r1);
      chk("bp_ready1", 32'(r1), 32'd0);
      chk("bp_hold", bus.o_res_data, saved);
    end
    bus.i_res_ready = 1'b1;
    cycle(r0, r1);
    chk("bp_release_ready1", 32'(r1), 32'd1);
    chk("bp_new_data", bus.o_res_data, 32'h0000_0018);

    // flush with a result held and both lanes requesting
    set_req(0, 1'b1, 32'h0000_0100, 5'd1, 2'b00, 6'd1);
    set_req(1, 1'b1, 32'h0000_0200, 5'd1, 2'b00, 6'd2);
    bus.i_res_ready = 1'b0;
    bus.i_flush = 1'b1;
    cycle(r0, r1);
    chk("fl_ready0", 32'(r0), 32'd0);
    chk("fl_ready1", 32'(r1), 32'd0);
    chk("fl_valid", 32'(bus.o_res_valid), 32'd0);
    bus.i_flush = 1'b0;
    cycle(r0, r1);
    chk("fl_after_ready0", 32'(r0), 32'd1);

    // mode 11 pass-through on lane 1
    set_req(0, 1'b0, 32'd0, 5'd0, 2'd0, 6'd0);
    set_req(1, 1'b1, 32'h1234_5678, 5'd7, 2'b11, 6'd33);
    bus.i_res_ready = 1'b1;
    #3;
    chk("m11_sh_mode", 32'(bus.o_sh_mode), 32'd3);
    #1;
    @(posedge clk);
    #1;
    m_valid = 1'b1; m_data = 32'h1234_5678; m_tag = 6'd33; m_lane = 1'b1; m_den = 0;
    chk("m11_data", bus.o_res_data, 32'h1234_5678);
    chk("m11_lane", 32'(bus.o_res_lane), 32'd1);

    // asynchronous reset between edges while a result is held
    bus.i_res_ready = 1'b0;
    set_req(0, 1'b1, 32'h0000_0055, 5'd1, 2'b01, 6'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.o_res_valid), 32'd0);
    chk("arst_data", bus.o_res_data, 32'd0);
    chk("arst_tag", 32'(bus.o_res_tag), 32'd0);
    chk("arst_lane", 32'(bus.o_res_lane), 32'd0);
    chk("arst_ready0", 32'(bus.o_req0_ready), 32'd0);
    chk("arst_sh_data", bus.o_sh_data, 32'd0);
    @(posedge clk);
    #1;
    chk("arst_ready0_held", 32'(bus.o_req0_ready), 32'd0);
    rst = 1'b0;
    model_reset();
    bus.i_res_ready = 1'b1;
    cycle(r0, r1);
    chk("arst_first_grant", 32'(r0), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.i_flush     = ($urandom_range(15) == 0);
      bus.i_res_ready = $urandom_range(3) != 0;
      set_req(0, 1'($urandom_range(1)), $urandom, 5'($urandom), 2'($urandom), 6'($urandom));
      set_req(1, 1'($urandom_range(1)), $urandom, 5'($urandom), 2'($urandom), 6'($urandom));
      cycle(r0, r1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/shift_unit_arbiter.md
SHIFT_UNIT_ARBITER -- requirements
Module: shift_unit_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning consecutive lane-1 denials before lane 1 is forced to win (range 1..7).
REQ-002 SHALL have parameter TAG_W, default 6, meaning width of the instruction tag carried with each request.
REQ-003 Clocking and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: i_clk  input  1  rising-edge clock.
REQ-005 SHALL have port: i_reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: i_flush  input  1  pipeline flush; discards held result, blocks grants this cycle.
REQ-007 SHALL have ports, for lane n in {0,1}: i_reqn_valid  input  1; i_reqn_data  input  32; i_reqn_amt  input  5; i_reqn_mode  input  2 (00 SRL, 01 SLL, 10 SRA, 11 reserved); i_reqn_tag  input  TAG_W; o_reqn_ready  output  1.
REQ-008 SHALL have ports: o_sh_data  output  32; o_sh_amt  output  5; o_sh_mode  output  2; i_sh_result  input  32 (drive / return of the shared combinational 32-bit shifter).
REQ-009 SHALL have ports: o_res_valid  output  1; o_res_data  output  32; o_res_tag  output  TAG_W; o_res_lane  output  1; i_res_ready  input  1.

Function
REQ-010 Lane 0 is the older issue slot; SHALL grant at most one request per cycle.
REQ-011 accept = ~i_flush & (~o_res_valid | i_res_ready); no grant when accept=0.
REQ-012 Grant rule when accept=1: only one valid -> that lane; both valid -> lane 0, unless starve_cnt == STARVE_LIMIT, then lane 1.
REQ-013 o_reqn_ready SHALL be 1 only for the granted lane in the granting cycle; a transfer occurs on valid & ready.
REQ-014 o_sh_data/o_sh_amt/o_sh_mode SHALL combinationally mirror the granted lane's fields; all zero when no grant.
REQ-015 On transfer, next edge SHALL load o_res_data=i_sh_result, o_res_tag=granted tag, o_res_lane=granted lane, o_res_valid=1; latency 1 cycle from transfer.
REQ-016 Mode 11 SHALL be forwarded unchanged; the result is whatever i_sh_result returns (pass-through), no error signalled.
REQ-017 o_res_valid & ~i_res_ready SHALL hold all o_res_* stable (no grant, no overwrite).
REQ-018 o_res_valid & i_res_ready & no new transfer SHALL clear o_res_valid next edge; with a new transfer the register reloads (back-to-back, full throughput).
REQ-019 starve_cnt (3 bits): increments when both lanes valid, accept=1, lane 0 granted; cleared when lane 1 granted or lane 1 not valid; holds when accept=0; saturates at STARVE_LIMIT.
REQ-020 i_flush=1 SHALL clear o_res_valid and starve_cnt next edge, deassert both readies that cycle, and take priority over i_res_ready and any request.
REQ-021 o_res_data/o_res_tag/o_res_lane SHALL keep last values when o_res_valid falls (no forced zeroing except reset).
REQ-022 Requesters SHALL be allowed to change fields while not granted; the block SHALL NOT require valid to remain asserted.

Reset
REQ-023 i_reset=1 SHALL immediately (asynchronously) set o_res_valid=0, o_res_data=0, o_res_tag=0, o_res_lane=0, starve_cnt=0.
REQ-024 During reset o_req0_ready=o_req1_ready=0 and o_sh_* = 0.
REQ-025 Reset asserted mid-transfer SHALL discard the in-flight request; first grant possible on the first edge after reset deasserts.

Verification
REQ-026 Single lane: req0 data=0x8000_0001 amt=4 mode=10 tag=5, res_ready=1, i_sh_result=0xF800_0000 -> ready0=1 same cycle; next cycle res_valid=1 data=0xF800_0000 tag=5 lane=0.
REQ-027 Contention: both lanes valid continuously, res_ready=1, STARVE_LIMIT=3 -> grant sequence 0,0,0,1,0,0,0,1; starve_cnt 0,1,2,3,0.
REQ-028 Backpressure: res_valid=1, res_ready=0 for 4 cycles with req1 valid -> ready1=0, outputs stable 4 cycles; ready1=1 in the cycle res_ready rises; new result next edge.
REQ-029 Flush: res_valid=1, both requests valid, i_flush=1 one cycle -> both readies 0 that cycle, res_valid=0 and starve_cnt=0 next edge, lane 0 granted the following cycle.
REQ-030 Async reset: assert i_reset between edges while res_valid=1 -> res_valid/data/tag/lane go 0 without a clock edge; readies 0 until reset released.
REQ-031 Mode 11: req1 mode=11 data=0x1234_5678 amt=7, i_sh_result=0x1234_5678 -> o_sh_mode=11, result 0x1234_5678 lane=1 one cycle later.
